duty_phase_silencer: RTL and testbench



---
 rtl/duty_phase_silencer.sv | 167 ++++++++++++++++
 tb/tb_duty_phase_silencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_phase_silencer.sv
// Time-multiplexed duty/phase slew limiter: one transducer per clock per update tick.
// Optional SILENCER_BYPASS_PORT_EN adds a BYPASS input that registers targets straight through.
module duty_phase_silencer #(
  parameter int TRANS_NUM = 249
) (
  input  logic                   CLK,
  input  logic                   RST,
`ifdef SILENCER_BYPASS_PORT_EN
  input  logic                   BYPASS,
`endif
  input  logic                   UPDATE,
  input  logic [7:0]             DUTY_STEP,
  input  logic [7:0]             PHASE_STEP,
  input  logic [8*TRANS_NUM-1:0] DUTY,
  input  logic [8*TRANS_NUM-1:0] PHASE,
  output logic [8*TRANS_NUM-1:0] DUTY_OUT,
  output logic [8*TRANS_NUM-1:0] PHASE_OUT,
  output logic                   DONE,
  output logic                   OVERRUN
);

  localparam int IW = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TRANS_NUM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    dstep_q, dstep_d;
  logic [7:0]    pstep_q, pstep_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          wr_en;
  logic          bypass;

  logic [7:0] duty_q  [TRANS_NUM];
  logic [7:0] phase_q [TRANS_NUM];

  logic [7:0] duty_tgt, duty_cur, duty_nxt, duty_diff;
  logic [7:0] phase_tgt, phase_cur, phase_nxt, phase_fwd, phase_back;

`ifdef SILENCER_BYPASS_PORT_EN
  assign bypass = BYPASS;
`else
  assign bypass = 1'b0;
`endif

  assign duty_tgt  = DUTY[{idx_q, 3'b000} +: 8];
  assign phase_tgt = PHASE[{idx_q, 3'b000} +: 8];
  assign duty_cur  = duty_q[idx_q];
  assign phase_cur = phase_q[idx_q];

  // Duty: clamp the move so it never overshoots the target.
  always_comb begin
    duty_nxt  = duty_cur;
    duty_diff = 8'd0;
    if (dstep_q == 8'd0) begin
      duty_nxt = duty_tgt;
    end else if (duty_tgt > duty_cur) begin
      duty_diff = duty_tgt - duty_cur;
      duty_nxt  = duty_cur + ((dstep_q < duty_diff) ? dstep_q : duty_diff);
    end else if (duty_tgt < duty_cur) begin
      duty_diff = duty_cur - duty_tgt;
      duty_nxt  = duty_cur - ((dstep_q < duty_diff) ? dstep_q : duty_diff);
    end
  end

  // Phase: shorter way round the circle; a half-turn distance goes forward.
  always_comb begin
    phase_fwd  = phase_tgt - phase_cur;
    phase_back = phase_cur - phase_tgt;
    phase_nxt  = phase_cur;
    if (pstep_q == 8'd0) begin
      phase_nxt = phase_tgt;
    end else if (phase_fwd == 8'd0) begin
      phase_nxt = phase_cur;
    end else if (phase_fwd <= 8'd128) begin
      phase_nxt = phase_cur + ((pstep_q < phase_fwd) ? pstep_q : phase_fwd);
    end else begin
      phase_nxt = phase_cur - ((pstep_q < phase_back) ? pstep_q : phase_back);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dstep_d = dstep_q;
    pstep_d = pstep_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    if (bypass) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (UPDATE) begin
            dstep_d = DUTY_STEP;
            pstep_d = PHASE_STEP;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          wr_en = 1'b1;
          if (UPDATE) ovr_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dstep_q <= 8'd0;
      pstep_q <= 8'd0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dstep_q <= dstep_d;
      pstep_q <= pstep_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        duty_q[i]  <= 8'd0;
        phase_q[i] <= 8'd0;
      end
    end else if (bypass) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        duty_q[i]  <= DUTY[8*i +: 8];
        phase_q[i] <= PHASE[8*i +: 8];
      end
    end else if (wr_en) begin
      duty_q[idx_q]  <= duty_nxt;
      phase_q[idx_q] <= phase_nxt;
    end
  end

  for (genvar g = 0; g < TRANS_NUM; g++) begin : g_out
    assign DUTY_OUT[8*g +: 8]  = duty_q[g];
    assign PHASE_OUT[8*g +: 8] = phase_q[g];
  end

  assign DONE    = done_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_duty_phase_silencer.sv
// Randomized bench for duty_phase_silencer against an arithmetic model of the slew rules.
// Covers scan timing, wrap/tie phase behaviour, overrun, mid-scan reset and optional bypass.
module tb_duty_phase_silencer;

  localparam int N = 249;

  logic           CLK = 1'b0;
  logic           RST;
  logic           UPDATE;
  logic [7:0]     DUTY_STEP, PHASE_STEP;
  logic [8*N-1:0] DUTY, PHASE, DUTY_OUT, PHASE_OUT;
  logic           DONE, OVERRUN;
`ifdef SILENCER_BYPASS_PORT_EN
  logic           BYPASS;
`endif

  duty_phase_silencer #(.TRANS_NUM(N)) dut (
    .CLK(CLK), .RST(RST),
`ifdef SILENCER_BYPASS_PORT_EN
    .BYPASS(BYPASS),
`endif
    .UPDATE(UPDATE), .DUTY_STEP(DUTY_STEP), .PHASE_STEP(PHASE_STEP),
    .DUTY(DUTY), .PHASE(PHASE), .DUTY_OUT(DUTY_OUT), .PHASE_OUT(PHASE_OUT),
    .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;
  int md [N];
  int mp [N];
  int td [N];
  int tp [N];
  logic o_done_pre, o_done_post;
  int o_pk_d, o_pk_p, o_pk1_d, o_pk1_p, e_pk_d, e_pk_p, e_pk1_d, e_pk1_p;

  function automatic int m_duty(int c, int t, int s);
    if (s == 0) return t;
    if (t > c) return c + (((t - c) < s) ? (t - c) : s);
    if (t < c) return c - (((c - t) < s) ? (c - t) : s);
    return c;
  endfunction

  function automatic int m_phase(int c, int t, int s);
    int d, delta, mag;
    if (s == 0) return t;
    d     = (t - c + 256) % 256;
    delta = (d <= 128) ? d : d - 256;
    mag   = (delta < 0) ? -delta : delta;
    if (mag > s) mag = s;
    return (c + ((delta < 0) ? -mag : mag) + 256) % 256;
  endfunction

  task automatic set_targets();
    for (int i = 0; i < N; i++) begin
      DUTY[8*i +: 8]  = 8'(td[i]);
      PHASE[8*i +: 8] = 8'(tp[i]);
    end
  endtask

  task automatic fill_targets(input int d, input int p);
    for (int i = 0; i < N; i++) begin td[i] = d; tp[i] = p; end
    set_targets();
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin md[i] = 0; mp[i] = 0; end
  endtask

  // Entered and left at posedge+1. extra_at: edge offset of a second UPDATE (0 = none).
  task automatic run_scan(input int extra_at, input int probe);
    int ds, ps;
    ds = int'(DUTY_STEP);
    ps = int'(PHASE_STEP);
    e_pk_d  = m_duty(md[probe], td[probe], ds);
    e_pk_p  = m_phase(mp[probe], tp[probe], ps);
    e_pk1_d = md[(probe + 1) % N];
    e_pk1_p = mp[(probe + 1) % N];
    UPDATE = 1'b1;
    @(posedge CLK); #1;
    UPDATE = 1'b0;
    for (int c = 1; c <= N; c++) begin
      UPDATE = (c == extra_at);
      @(posedge CLK); #1;
      UPDATE = 1'b0;
      if (c - 1 == probe) begin
        o_pk_d  = int'(DUTY_OUT[8*probe +: 8]);
        o_pk_p  = int'(PHASE_OUT[8*probe +: 8]);
        o_pk1_d = int'(DUTY_OUT[8*((probe + 1) % N) +: 8]);
        o_pk1_p = int'(PHASE_OUT[8*((probe + 1) % N) +: 8]);
      end
      if (c == N - 1) o_done_pre = DONE;
      if (c == N) o_done_post = DONE;
    end
    for (int i = 0; i < N; i++) begin
      md[i] = m_duty(md[i], td[i], ds);
      mp[i] = m_phase(mp[i], tp[i], ps);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      vecs++;
      if (DUTY_OUT[8*i +: 8] !== 8'd0 || PHASE_OUT[8*i +: 8] !== 8'd0) begin
        errs++;
        $display("FAIL reset_out[%0d] got duty %0d phase %0d exp 0", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8]);
      end
    end
    vecs++;
    if (DONE !== 1'b0 || OVERRUN !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags got done %b overrun %b exp 0 0", DONE, OVERRUN);
    end
    RST = 1'b0;
    clear_model();
  endtask

  task automatic test_duty_ramp();
    int exp_d;
    fill_targets(200, 0);
    DUTY_STEP  = 8'd50;
    PHASE_STEP = 8'd0;
    for (int n = 1; n <= 5; n++) begin
      run_scan(0, 0);
      exp_d = (50 * n > 200) ? 200 : 50 * n;
      vecs++;
      if (o_done_pre !== 1'b0 || o_done_post !== 1'b1) begin
        errs++;
        $display("FAIL ramp_done scan %0d got pre %b post %b exp 0 1", n, o_done_pre, o_done_post);
      end
      vecs++;
      if (DUTY_OUT[7:0] !== 8'(exp_d) || DUTY_OUT[8*(N-1) +: 8] !== 8'(exp_d)) begin
        errs++;
        $display("FAIL ramp_value scan %0d got %0d/%0d exp %0d", n, DUTY_OUT[7:0], DUTY_OUT[8*(N-1) +: 8], exp_d);
      end
      for (int i = 0; i < N; i++) begin
        vecs++;
        if (DUTY_OUT[8*i +: 8] !== 8'(md[i]) || PHASE_OUT[8*i +: 8] !== 8'(mp[i])) begin
          errs++;
          $display("FAIL ramp_model[%0d] got %0d/%0d exp %0d/%0d", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8], md[i], mp[i]);
        end
      end
      vecs++;
      @(posedge CLK); #1;
      if (DONE !== 1'b0) begin
        errs++;
        $display("FAIL ramp_done_width got %b exp 0", DONE);
      end
      repeat (300 - N - 2) @(posedge CLK);
      #1;
    end
  endtask

  task automatic phase_seq(input string name, input int start, input int tgt, input int step, input int cnt, input int exp_seq [5]);
    fill_targets(200, start);
    PHASE_STEP = 8'd0;
    run_scan(0, 0);
    fill_targets(200, tgt);
    PHASE_STEP = 8'(step);
    for (int n = 0; n < cnt; n++) begin
      run_scan(0, 0);
      for (int i = 0; i < N; i++) begin
        vecs++;
        if (PHASE_OUT[8*i +: 8] !== 8'(exp_seq[n]) || PHASE_OUT[8*i +: 8] !== 8'(mp[i])) begin
          errs++;
          $display("FAIL %s step %0d [%0d] got %0d exp %0d model %0d", name, n, i, PHASE_OUT[8*i +: 8], exp_seq[n], mp[i]);
        end
      end
    end
  endtask

  task automatic test_phase_wrap();
    int s1 [5] = '{254, 2, 5, 5, 5};
    int s2 [5] = '{130, 130, 130, 130, 130};
    phase_seq("phase_wrap", 250, 5, 4, 4, s1);
    phase_seq("phase_tie", 2, 130, 200, 1, s2);
  endtask

  task automatic test_phase_back();
    int s [5] = '{250, 234, 218, 202, 200};
    phase_seq("phase_back", 10, 200, 16, 5, s);
  endtask

  task automatic test_step_zero();
    for (int i = 0; i < N; i++) begin td[i] = int'($urandom_range(0, 255)); tp[i] = int'($urandom_range(0, 255)); end
    set_targets();
    DUTY_STEP  = 8'd0;
    PHASE_STEP = 8'd0;
    run_scan(0, 0);
    fill_targets(77, 33);
    run_scan(0, N - 1);
    for (int i = 0; i < N; i++) begin
      vecs++;
      if (DUTY_OUT[8*i +: 8] !== 8'd77 || PHASE_OUT[8*i +: 8] !== 8'd33) begin
        errs++;
        $display("FAIL step_zero[%0d] got %0d/%0d exp 77/33", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8]);
      end
    end
  endtask

  task automatic test_random();
    int probe;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) begin td[i] = int'($urandom_range(0, 255)); tp[i] = int'($urandom_range(0, 255)); end
      set_targets();
      DUTY_STEP  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      PHASE_STEP = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      probe = (n == 0) ? 0 : (n == 1) ? N - 2 : int'($urandom_range(0, N - 1));
      run_scan(0, probe);
      vecs++;
      if (o_pk_d != e_pk_d || o_pk_p != e_pk_p) begin
        errs++;
        $display("FAIL rand_probe[%0d] got %0d/%0d exp %0d/%0d", probe, o_pk_d, o_pk_p, e_pk_d, e_pk_p);
      end
      if (probe < N - 1) begin
        vecs++;
        if (o_pk1_d != e_pk1_d || o_pk1_p != e_pk1_p) begin
          errs++;
          $display("FAIL rand_early[%0d] got %0d/%0d exp %0d/%0d", probe + 1, o_pk1_d, o_pk1_p, e_pk1_d, e_pk1_p);
        end
      end
      for (int i = 0; i < N; i++) begin
        vecs++;
        if (DUTY_OUT[8*i +: 8] !== 8'(md[i]) || PHASE_OUT[8*i +: 8] !== 8'(mp[i])) begin
          errs++;
          $display("FAIL rand_model[%0d] got %0d/%0d exp %0d/%0d", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8], md[i], mp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    DUTY_STEP  = 8'd3;
    PHASE_STEP = 8'd5;
    for (int i = 0; i < N; i++) begin td[i] = int'($urandom_range(0, 255)); tp[i] = int'($urandom_range(0, 255)); end
    set_targets();
    run_scan(0, 0);
    run_scan(0, 0);
    vecs++;
    if (OVERRUN !== 1'b0) begin
      errs++;
      $display("FAIL b2b_overrun got %b exp 0", OVERRUN);
    end
    run_scan(N, 0);
    for (int i = 0; i < N; i++) begin td[i] = int'($urandom_range(0, 255)); tp[i] = int'($urandom_range(0, 255)); end
    set_targets();
    repeat (260) @(posedge CLK);
    #1;
    vecs++;
    if (OVERRUN !== 1'b1) begin
      errs++;
      $display("FAIL last_cycle_overrun got %b exp 1", OVERRUN);
    end
    for (int i = 0; i < N; i++) begin
      vecs++;
      if (DUTY_OUT[8*i +: 8] !== 8'(md[i]) || PHASE_OUT[8*i +: 8] !== 8'(mp[i])) begin
        errs++;
        $display("FAIL dropped_update[%0d] got %0d/%0d exp %0d/%0d", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8], md[i], mp[i]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    DUTY_STEP  = 8'd20;
    PHASE_STEP = 8'd9;
    for (int i = 0; i < N; i++) begin td[i] = int'($urandom_range(0, 255)); tp[i] = int'($urandom_range(0, 255)); end
    set_targets();
    run_scan(100, 0);
    for (int i = 0; i < N; i++) begin
      vecs++;
      if (DUTY_OUT[8*i +: 8] !== 8'(md[i]) || PHASE_OUT[8*i +: 8] !== 8'(mp[i])) begin
        errs++;
        $display("FAIL overrun_scan[%0d] got %0d/%0d exp %0d/%0d", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8], md[i], mp[i]);
      end
    end
    repeat (300) @(posedge CLK);
    #1;
    vecs++;
    if (OVERRUN !== 1'b1) begin
      errs++;
      $display("FAIL overrun_sticky got %b exp 1", OVERRUN);
    end
    // Second update while idle starts a scan; reset lands while idx is 120.
    UPDATE = 1'b1;
    @(posedge CLK); #1;
    UPDATE = 1'b0;
    repeat (120) @(posedge CLK);
    #1;
    vecs++;
    if (DUTY_OUT[8*119 +: 8] !== 8'(m_duty(md[119], td[119], 20))) begin
      errs++;
      $display("FAIL pre_abort[119] got %0d exp %0d", DUTY_OUT[8*119 +: 8], m_duty(md[119], td[119], 20));
    end
    RST = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      vecs++;
      if (DUTY_OUT[8*i +: 8] !== 8'd0 || PHASE_OUT[8*i +: 8] !== 8'd0) begin
        errs++;
        $display("FAIL abort_zero[%0d] got %0d/%0d exp 0/0", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8]);
      end
    end
    vecs++;
    if (OVERRUN !== 1'b0 || DONE !== 1'b0) begin
      errs++;
      $display("FAIL abort_flags got overrun %b done %b exp 0 0", OVERRUN, DONE);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    clear_model();
  endtask

`ifdef SILENCER_BYPASS_PORT_EN
  task automatic test_bypass();
    BYPASS = 1'b1;
    @(posedge CLK); #1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < N; i++) begin td[i] = int'($urandom_range(0, 255)); tp[i] = int'($urandom_range(0, 255)); end
      set_targets();
      UPDATE = 1'b1;
      @(posedge CLK); #1;
      UPDATE = 1'b0;
      for (int i = 0; i < N; i++) begin
        vecs++;
        if (DUTY_OUT[8*i +: 8] !== 8'(td[i]) || PHASE_OUT[8*i +: 8] !== 8'(tp[i])) begin
          errs++;
          $display("FAIL bypass[%0d] got %0d/%0d exp %0d/%0d", i, DUTY_OUT[8*i +: 8], PHASE_OUT[8*i +: 8], td[i], tp[i]);
        end
      end
    end
    repeat (N + 5) @(posedge CLK);
    #1;
    vecs++;
    if (OVERRUN !== 1'b0 || DONE !== 1'b0) begin
      errs++;
      $display("FAIL bypass_flags got overrun %b done %b exp 0 0", OVERRUN, DONE);
    end
    BYPASS = 1'b0;
    for (int i = 0; i < N; i++) begin md[i] = td[i]; mp[i] = tp[i]; end
  endtask
`endif

  initial begin
    RST = 1'b1;
    UPDATE = 1'b0;
    DUTY_STEP = 8'd0;
    PHASE_STEP = 8'd0;
`ifdef SILENCER_BYPASS_PORT_EN
    BYPASS = 1'b0;
`endif
    fill_targets(0, 0);
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    test_duty_ramp();
    test_phase_wrap();
    test_phase_back();
    test_step_zero();
    test_random();
    test_back_to_back();
    test_overrun();
`ifdef SILENCER_BYPASS_PORT_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
